// File: rtl/md_unit_iter.sv
// rtl/md_unit_iter.sv - iterative radix-2 RV32M multiply/divide unit
//   i_clk, i_rst_n          : clock, synchronous active-low reset
//   i_valid/o_ready         : request handshake (i_op_a, i_op_b, i_md_op = funct3)
//   o_valid/i_ready         : result handshake (o_md_data)
//   i_flush                 : abandon the in-flight operation
module md_unit_iter #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_op_a,
  input  logic [XLEN-1:0] i_op_b,
  input  logic [2:0]      i_md_op,
  input  logic            i_flush,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_md_data
);

  localparam int CW = $clog2(XLEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_CALC  = 2'd1;
  localparam logic [1:0] S_FIXUP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

  logic [1:0]      state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op_q;
  logic            neg_q;      // operand signs differ: negate product / quotient
  logic            rem_neg_q;  // dividend negative: negate remainder
  logic [XLEN-1:0] mag_q;      // multiplicand (mul) or divisor (div) magnitude
  logic [XLEN-1:0] hi;         // product high half / partial remainder
  logic [XLEN-1:0] lo;         // multiplier bits / quotient bits

  // ---------------- accept-side decode ----------------
  logic            a_signed, b_signed, a_neg, b_neg;
  logic [XLEN-1:0] mag_a_in, mag_b_in;
  logic            is_div, div_zero, div_ovf;
  logic [XLEN-1:0] special_res;
  logic            accept;

  always_comb begin
    a_signed = 1'b0;
    b_signed = 1'b0;
    case (i_md_op)
      3'b000, 3'b001, 3'b100, 3'b110: begin a_signed = 1'b1; b_signed = 1'b1; end
      3'b010:                         begin a_signed = 1'b1; b_signed = 1'b0; end
      default:                        begin a_signed = 1'b0; b_signed = 1'b0; end
    endcase
  end

  assign a_neg    = a_signed & i_op_a[XLEN-1];
  assign b_neg    = b_signed & i_op_b[XLEN-1];
  assign mag_a_in = a_neg ? -i_op_a : i_op_a;
  assign mag_b_in = b_neg ? -i_op_b : i_op_b;

  assign is_div   = i_md_op[2];
  assign div_zero = is_div & (i_op_b == '0);
  assign div_ovf  = is_div & ~i_md_op[0] & (i_op_a == INT_MIN) & (&i_op_b);

  // funct3[1] selects remainder among the divide ops
  always_comb begin
    special_res = '0;
    if (div_zero)
      special_res = i_md_op[1] ? i_op_a : '1;
    else
      special_res = i_md_op[1] ? '0 : i_op_a;
  end

  assign o_ready = i_rst_n & (state == S_IDLE);
  assign o_valid = (state == S_DONE);
  assign accept  = i_valid & o_ready & ~i_flush;

  // ---------------- iteration datapath ----------------
  // Multiply: add multiplicand into the high half when the current multiplier
  // bit is set, then shift the whole {carry, hi, lo} right by one.
  logic [XLEN:0]   mul_sum;
  // Divide: shift the next dividend bit into an XLEN+1 bit partial remainder
  // and subtract the divisor when it fits; the restored value always fits XLEN.
  logic [XLEN:0]   shifted;
  logic            q_bit;
  logic [XLEN-1:0] rem_sub;

  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, mag_q} : '0);
  assign shifted = {hi, lo[XLEN-1]};
  assign q_bit   = (shifted >= {1'b0, mag_q});
  assign rem_sub = shifted[XLEN-1:0] - mag_q;

  // ---------------- sign fixup and result select ----------------
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix, result;

  assign prod_fix = neg_q ? -{hi, lo} : {hi, lo};
  assign quo_fix  = neg_q ? -lo : lo;
  assign rem_fix  = rem_neg_q ? -hi : hi;

  always_comb begin
    result = '0;
    case (op_q)
      3'b000:                 result = prod_fix[XLEN-1:0];
      3'b001, 3'b010, 3'b011: result = prod_fix[2*XLEN-1:XLEN];
      3'b100, 3'b101:         result = quo_fix;
      default:                result = rem_fix;
    endcase
  end

  // ---------------- state ----------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      mag_q     <= '0;
      hi        <= '0;
      lo        <= '0;
      o_md_data <= '0;
    end else if (i_flush) begin
      state <= S_IDLE;
    end else begin
      case (state)
        S_IDLE: begin
          if (accept) begin
            op_q      <= i_md_op;
            neg_q     <= a_neg ^ b_neg;
            rem_neg_q <= a_neg;
            hi        <= '0;
            if (is_div) begin
              mag_q <= mag_b_in;
              lo    <= mag_a_in;
            end else begin
              mag_q <= mag_a_in;
              lo    <= mag_b_in;
            end
            if (div_zero | div_ovf) begin
              o_md_data <= special_res;
              state     <= S_DONE;
            end else begin
              cnt   <= CW'(XLEN - 1);
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (op_q[2]) begin
            hi <= q_bit ? rem_sub : shifted[XLEN-1:0];
            lo <= {lo[XLEN-2:0], q_bit};
          end else begin
            hi <= mul_sum[XLEN:1];
            lo <= {mul_sum[0], lo[XLEN-1:1]};
          end
          if (cnt == '0)
            state <= S_FIXUP;
          else
            cnt <= cnt - CW'(1);
        end
        S_FIXUP: begin
          o_md_data <= result;
          state     <= S_DONE;
        end
        default: begin
          if (i_ready)
            state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_md_unit_iter.sv
// tb/tb_md_unit_iter.sv - self-checking bench for md_unit_iter
module tb_md_unit_iter;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_op_a;
  logic [31:0] i_op_b;
  logic [2:0]  i_md_op;
  logic        i_flush;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_md_data;

  int n_pass  = 0;
  int n_total = 0;

  always #5 i_clk = ~i_clk;

  md_unit_iter #(.XLEN(32)) dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_op_a    (i_op_a),
    .i_op_b    (i_op_b),
    .i_md_op   (i_md_op),
    .i_flush   (i_flush),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_md_data (o_md_data)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  // RISC-V M reference, computed with wide integer arithmetic
  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    longint            sa, sb, ub;
    logic signed [63:0] ps;
    logic [63:0]        pu;
    logic [31:0]        r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'h0, b});
    r  = '0;
    case (op)
      3'd0: begin ps = sa * sb; r = ps[31:0];  end
      3'd1: begin ps = sa * sb; r = ps[63:32]; end
      3'd2: begin ps = sa * ub; r = ps[63:32]; end
      3'd3: begin pu = {32'h0, a} * {32'h0, b}; r = pu[63:32]; end
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = $signed(a) / $signed(b);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
        else r = $signed(a) % $signed(b);
      end
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    while (o_ready !== 1'b1 && n < 100) begin tick(); n++; end
    if (n >= 100) chk({tag, " ready timeout"}, {31'b0, o_ready}, 32'd1);
  endtask

  // Issue one request, measure edges to o_valid, check result, then
  // hold the result for `stall` cycles before taking it.
  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                       input int stall);
    int lat;
    wait_ready(tag);
    i_valid = 1'b1; i_md_op = op; i_op_a = a; i_op_b = b;
    tick();
    i_valid = 1'b0; i_op_a = $urandom; i_op_b = $urandom; i_md_op = 3'($urandom);
    lat = 1;
    while (o_valid !== 1'b1 && lat < 200) begin tick(); lat++; end
    chk({tag, " valid"}, {31'b0, o_valid}, 32'd1);
    if (exp_lat > 0) chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " data"}, o_md_data, exp);
    repeat (stall) tick();
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
  endtask

  initial begin
    logic [2:0]  op;
    logic [31:0] a, b;
    int          lat, hits;

    i_rst_n = 1'b0; i_valid = 1'b0; i_op_a = '0; i_op_b = '0;
    i_md_op = '0; i_flush = 1'b0; i_ready = 1'b0;

    // reset state
    tick(); tick();
    chk("reset o_valid", {31'b0, o_valid}, 32'd0);
    chk("reset o_ready", {31'b0, o_ready}, 32'd0);
    chk("reset data", o_md_data, 32'd0);
    i_rst_n = 1'b1;
    #1;
    chk("post-reset o_ready", {31'b0, o_ready}, 32'd1);

    // multiply
    do_op("MUL",    3'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFF9, 34, 0);
    do_op("MULH",   3'd1, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 34, 0);
    do_op("MULHSU", 3'd2, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 34, 0);
    do_op("MULHU",  3'd3, 32'hFFFF_FFFF, 32'd7, 32'h0000_0006, 34, 0);

    // divide
    do_op("DIV -20/3",  3'd4, -32'sd20, 32'd3,   32'hFFFF_FFFA, 34, 0);
    do_op("REM -20/3",  3'd6, -32'sd20, 32'd3,   32'hFFFF_FFFE, 34, 0);
    do_op("DIVU 20/3",  3'd5, 32'd20,   32'd3,   32'd6,         34, 0);
    do_op("REMU 20/3",  3'd7, 32'd20,   32'd3,   32'd2,         34, 0);
    do_op("REM 20/-3",  3'd6, 32'd20,   -32'sd3, 32'd2,         34, 0);

    // special cases
    do_op("DIV 5/0",    3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0);
    do_op("REM 5/0",    3'd6, 32'd5, 32'd0, 32'd5,         1, 0);
    do_op("DIV ovf",    3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0);
    do_op("REM ovf",    3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, 0);

    // backpressure: hold result with i_valid pulses, then release
    wait_ready("bp");
    i_valid = 1'b1; i_md_op = 3'd0; i_op_a = 32'd3; i_op_b = 32'd5;
    tick();
    i_valid = 1'b0;
    lat = 1;
    while (o_valid !== 1'b1 && lat < 200) begin tick(); lat++; end
    for (int i = 0; i < 5; i++) begin
      i_valid = 1'b1; i_md_op = 3'd1; i_op_a = $urandom; i_op_b = $urandom;
      chk("bp o_valid", {31'b0, o_valid}, 32'd1);
      chk("bp data", o_md_data, 32'd15);
      chk("bp o_ready", {31'b0, o_ready}, 32'd0);
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    tick();
    i_ready = 1'b0;
    chk("bp release o_ready", {31'b0, o_ready}, 32'd1);
    chk("bp release o_valid", {31'b0, o_valid}, 32'd0);
    do_op("bp next DIVU", 3'd5, 32'd100, 32'd7, 32'd14, 34, 0);

    // flush on the 10th edge of a DIV
    i_valid = 1'b1; i_md_op = 3'd4; i_op_a = 32'd1000; i_op_b = 32'd7;
    tick();
    i_valid = 1'b0;
    repeat (8) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    chk("flush o_valid", {31'b0, o_valid}, 32'd0);
    chk("flush o_ready", {31'b0, o_ready}, 32'd1);
    chk("flush data", o_md_data, 32'd14);
    hits = 0;
    repeat (40) begin tick(); if (o_valid !== 1'b0) hits++; end
    chk("flush no valid", hits, 0);
    chk("flush data kept", o_md_data, 32'd14);

    // flush together with valid in IDLE: no accept
    i_valid = 1'b1; i_flush = 1'b1; i_md_op = 3'd0; i_op_a = 32'd2; i_op_b = 32'd2;
    tick();
    i_valid = 1'b0; i_flush = 1'b0;
    chk("flush+valid o_ready", {31'b0, o_ready}, 32'd1);
    hits = 0;
    repeat (40) begin tick(); if (o_valid !== 1'b0) hits++; end
    chk("flush+valid no valid", hits, 0);

    // flush in DONE beats i_ready
    i_valid = 1'b1; i_md_op = 3'd5; i_op_a = 32'd9; i_op_b = 32'd0;
    tick();
    i_valid = 1'b0;
    chk("done-flush valid", {31'b0, o_valid}, 32'd1);
    i_flush = 1'b1; i_ready = 1'b1;
    tick();
    i_flush = 1'b0; i_ready = 1'b0;
    chk("done-flush dropped", {31'b0, o_valid}, 32'd0);
    chk("done-flush o_ready", {31'b0, o_ready}, 32'd1);

    // reset mid-CALC
    i_valid = 1'b1; i_md_op = 3'd4; i_op_a = 32'd1000; i_op_b = 32'd7;
    tick();
    i_valid = 1'b0;
    repeat (8) tick();
    i_rst_n = 1'b0;
    tick();
    chk("rst-mid o_valid", {31'b0, o_valid}, 32'd0);
    chk("rst-mid o_ready", {31'b0, o_ready}, 32'd0);
    chk("rst-mid data", o_md_data, 32'd0);
    i_rst_n = 1'b1;
    #1;
    chk("rst-mid release o_ready", {31'b0, o_ready}, 32'd1);
    hits = 0;
    repeat (40) begin tick(); if (o_valid !== 1'b0) hits++; end
    chk("rst-mid no valid", hits, 0);

    // random regression against the reference model
    for (int n = 0; n < 1500; n++) begin
      op = 3'($urandom);
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = $urandom_range(0, 15);
        3: begin a = $urandom_range(0, 100); b = -$urandom_range(1, 9); end
        default: ;
      endcase
      lat = (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            ? 1 : 34;
      do_op("rand", op, a, b, ref_md(op, a, b), lat, $urandom_range(0, 3));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
